restador_bcd_serie: RTL and testbench
=====================================

// Module: restador_bcd_serie
// PURPOSE
//  Multi-digit BCD subtractor, digit-serial: Z = |A - B| plus a sign flag, one BCD digit per clock.
//  Successor of the single-nibble binary subtractor; generalised to NDIG digits with true decimal borrow.
//  Negative results are returned as sign+magnitude via a second ten's-complement pass.
//  Sits between BCD operand capture (keypad/regs) and 7-seg display driver; valid/ready on both sides.
// PARAMETERS
//  NDIG   4   number of BCD digits per operand/result (>=1); data width = 4*NDIG
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        operands A/B valid
//  in_ready   out  1        block idle, can accept operands
//  a_i        in   4*NDIG   minuend, packed BCD, digit 0 = bits [3:0] (LS digit)
//  b_i        in   4*NDIG   subtrahend, packed BCD
//  out_valid  out  1        z_o/neg_o/err_o valid
//  out_ready  in   1        consumer takes result
//  z_o        out  4*NDIG   magnitude |A-B|, packed BCD
//  neg_o      out  1        1 = A<B
//  err_o      out  1        invalid BCD input digit (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, z_o=0, neg_o=0, err_o=0, digit counter=0, borrow=0.
//  FSM: IDLE -> SUB -> (NEG) -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready at edge k: capture a_i/b_i into shift regs, borrow=0, cnt=0 -> SUB.
//   SUB: per cycle, digit i (LS first): t = a_i - b_i - borrow (5-bit signed); if t<0 {d=t+10, borrow=1} else {d=t, borrow=0}.
//        d shifted into result reg MS end. After digit NDIG-1: borrow=0 -> DONE; borrow=1 -> NEG, cnt=0, borrow=0.
//   NEG: per cycle, digit i of result: d' = 0 - d_i - borrow with same +10 correction (ten's complement). After NDIG digits -> DONE, neg=1.
//   DONE: out_valid=1; z_o/neg_o/err_o held stable until out_valid&out_ready -> IDLE (out_valid=0 next cycle).
//  Latency: out_valid rises NDIG clocks after accept edge if A>=B; 2*NDIG clocks if A<B.
//  Throughput: no overlap; in_ready=0 from accept through DONE handshake; next accept earliest the cycle after out handshake.
//  A==B: z_o=0, neg_o=0 (never "negative zero"). Final borrow out of NEG pass is discarded.
//  in_valid while busy: ignored, operands not sampled; a_i/b_i need only be stable on the accept edge.
//  out_ready low in DONE: indefinite hold, no loss. out_ready with out_valid=0: no effect.
//  Reset mid-operation: abort immediately to reset values; partial result discarded, no out_valid.
//  Outputs are registered; no combinational path in->out.
// CONFIGURATION
//  BCD_CHECK_EN defined: at accept, any digit of a_i or b_i >9 sets err flag; operation still runs NDIG/2*NDIG cycles,
//   but in DONE z_o=0, neg_o=0, err_o=1. Flag cleared on next accept.
//  BCD_CHECK_EN undefined: err_o tied 0; non-BCD digits processed as-is by the digit rule (result unspecified, no hang).
// STRUCTURE
//  Package restador_bcd_pkg: DIGIT_W=4, BCD_BASE=10, BCD_MAX=9, state enum {ST_IDLE,ST_SUB,ST_NEG,ST_DONE}.
//  Sub-module bcd_digit_resta (combinational): a[3:0], b[3:0], bin -> d[3:0], bout; shared by SUB and NEG
//   (NEG drives a=0, b=result digit). Top holds FSM, counter (clog2(NDIG) bits), shift regs, handshake.
// TESTING (NDIG=4)
//  A=5000, B=1234 -> z_o=3766, neg_o=0, out_valid 4 clk after accept.
//  A=1234, B=5000 -> z_o=3766, neg_o=1, out_valid 8 clk after accept.
//  A=0000, B=0001 -> z_o=0001, neg_o=1; A=B=9999 -> z_o=0000, neg_o=0; A=1000,B=0001 -> 0999 (borrow chain).
//  out_ready low 5 clk in DONE -> z_o/neg_o stable, in_ready=0, in_valid pulses ignored; then handshake -> IDLE.
//  rst_n low for 1 clk during SUB digit 2 -> all outputs reset at once, no out_valid; next op correct.
//  BCD_CHECK_EN: A=12A4 -> err_o=1, z_o=0, neg_o=0; next valid op clears err_o. Random A/B vs model, both builds.

Source files
------------

// File: rtl/restador_bcd_serie_pkg.sv
// Shared constants, FSM state type and BCD helpers for the digit-serial
// BCD subtractor restador_bcd_serie.
package restador_bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_BASE = 10;
  localparam int BCD_MAX  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_NEG,
    ST_DONE
  } state_e;

  // True when a nibble holds a legal decimal digit.
  function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] d);
    return (int'(d) <= BCD_MAX);
  endfunction

endpackage

// File: rtl/restador_bcd_serie_if.sv
// Operand/result handshake bundle for restador_bcd_serie.
// slave  : the subtractor (accepts operands, offers results).
// master : the surrounding logic (offers operands, consumes results).
interface restador_bcd_serie_if #(
  parameter int NDIG = 4
);
  localparam int W = 4 * NDIG;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z_o;
  logic         neg_o;
  logic         err_o;

  modport slave (
    input  in_valid, a_i, b_i, out_ready,
    output in_ready, out_valid, z_o, neg_o, err_o
  );

  modport master (
    output in_valid, a_i, b_i, out_ready,
    input  in_ready, out_valid, z_o, neg_o, err_o
  );
endinterface

// File: rtl/restador_bcd_serie_digit.sv
// One-digit decimal subtractor with borrow: d = a - b - bin, corrected by
// +10 when the raw difference goes negative. Purely combinational; used for
// both the magnitude pass (a - b) and the ten's-complement pass (0 - d).
module bcd_digit_resta
  import restador_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // 5-bit two's complement covers the full -16..15 range of nibble inputs.
  logic [DIGIT_W:0] t;

  // Raw difference, sign becomes the borrow out, negative values wrap by +10.
  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    bout = t[DIGIT_W];
    d    = bout ? (t[DIGIT_W-1:0] + DIGIT_W'(BCD_BASE)) : t[DIGIT_W-1:0];
  end

endmodule

// File: rtl/restador_bcd_serie.sv
// Digit-serial multi-digit BCD subtractor: Z = |A - B| with sign flag,
// one digit per clock, LS digit first. A negative raw result is turned
// into sign+magnitude by a second ten's-complement pass over the result.
// Optional build macro: BCD_CHECK_EN -- flag non-BCD operand digits on
// err_o and force a zero result for that operation.
module restador_bcd_serie
  import restador_bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  restador_bcd_serie_if.slave  bus
);

  localparam int W     = DIGIT_W * NDIG;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     z_q, z_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef BCD_CHECK_EN
  logic             err_q, err_d;
  logic             bad_digit;
`endif

  logic [DIGIT_W-1:0] dig_a, dig_b, dig_d;
  logic               dig_bout;

  bcd_digit_resta u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (borrow_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

`ifdef BCD_CHECK_EN
  // Scan every operand nibble for a value above 9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!digit_is_bcd(bus.a_i[i*DIGIT_W +: DIGIT_W]) ||
          !digit_is_bcd(bus.b_i[i*DIGIT_W +: DIGIT_W]))
        bad_digit = 1'b1;
    end
  end
`endif

  // Next-state, datapath steering and registered-output values.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    z_d      = z_q;
    neg_d    = neg_q;
    dig_a    = '0;
    dig_b    = '0;
`ifdef BCD_CHECK_EN
    err_d    = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_sh_d   = bus.a_i;
          b_sh_d   = bus.b_i;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SUB;
`ifdef BCD_CHECK_EN
          err_d    = bad_digit;
`endif
        end
      end

      ST_SUB: begin
        dig_a    = a_sh_q[DIGIT_W-1:0];
        dig_b    = b_sh_q[DIGIT_W-1:0];
        a_sh_d   = a_sh_q >> DIGIT_W;
        b_sh_d   = b_sh_q >> DIGIT_W;
        res_d    = (res_q >> DIGIT_W) | (W'(dig_d) << (W - DIGIT_W));
        borrow_d = dig_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (dig_bout) begin
            // A < B: re-run over the result as 0 - result.
            borrow_d = 1'b0;
            state_d  = ST_NEG;
          end else begin
            z_d     = res_d;
            neg_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      ST_NEG: begin
        dig_a    = '0;
        dig_b    = res_q[DIGIT_W-1:0];
        res_d    = (res_q >> DIGIT_W) | (W'(dig_d) << (W - DIGIT_W));
        borrow_d = dig_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Borrow out of the complement pass carries no information.
          cnt_d    = '0;
          borrow_d = 1'b0;
          z_d      = res_d;
          neg_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef BCD_CHECK_EN
    // Invalid operands still take the normal number of cycles, but the
    // presented result is blanked.
    if (err_q && (state_q != ST_DONE) && (state_d == ST_DONE)) begin
      z_d   = '0;
      neg_d = 1'b0;
    end
`endif

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      z_q         <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef BCD_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z_o       = z_q;
  assign bus.neg_o     = neg_q;
`ifdef BCD_CHECK_EN
  assign bus.err_o     = err_q;
`else
  assign bus.err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_restador_bcd_serie.sv
// Self-checking bench for restador_bcd_serie (NDIG=4): directed vector
// table, hold/backpressure and mid-operation reset sequences, then random
// operands against an integer-arithmetic reference model.
// Build with BCD_CHECK_EN defined to also exercise the invalid-digit flag.
module tb_restador_bcd_serie;

  localparam int NDIG    = 4;
  localparam int W       = 4 * NDIG;
  localparam int TIMEOUT = 100;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  restador_bcd_serie_if #(.NDIG(NDIG)) bus ();

  restador_bcd_serie #(.NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic         neg;
    int           lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------
  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < NDIG; i++)
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] z, output logic neg,
                       output logic err, output int lat);
    int ia = bcd_to_int(a);
    int ib = bcd_to_int(b);
    err = 1'b0;
`ifdef BCD_CHECK_EN
    err = has_bad_digit(a, b);
`endif
    neg = (ia < ib);
    z   = int_to_bcd(neg ? ib - ia : ia - ib);
    lat = neg ? 2 * NDIG : NDIG;
    if (err) begin
      z   = '0;
      neg = 1'b0;
      lat = -1;  // depends on raw nibble arithmetic; not checked
    end
  endtask

  // ---------------- bus helpers (drive and sample on negedge) ----------
  // Offer operands until accepted; returns at the negedge after the accept edge.
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("accept_timeout", n, 0);
    bus.a_i      = a;
    bus.b_i      = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a_i      = $urandom();
    bus.b_i      = $urandom();
  endtask

  // Count negedges until out_valid; lat is clocks since the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= TIMEOUT) check("done_timeout", lat, 0);
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 1'b0);
    check("in_ready_back", bus.in_ready, 1'b1);
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic chk_lat);
    logic [W-1:0] ez;
    logic         eneg, eerr;
    int           elat, lat;
    model(a, b, ez, eneg, eerr, elat);
    accept_op(a, b);
    check({tag, "_busy"}, bus.in_ready, 1'b0);
    wait_done(lat);
    check({tag, "_z"}, bus.z_o, ez);
    check({tag, "_neg"}, bus.neg_o, eneg);
    check({tag, "_err"}, bus.err_o, eerr);
    if (chk_lat && elat >= 0) check({tag, "_lat"}, lat, elat);
    take_result();
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    for (int i = 0; i < NDIG; i++) begin
      v[i*4 +: 4] = 4'($urandom_range(0, 9));
`ifdef BCD_CHECK_EN
      if ($urandom_range(0, 19) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
`endif
    end
    return v;
  endfunction

  vec_t vecs[6];

  initial begin
    logic [W-1:0] z_snap;
    logic         neg_snap;
    logic         saw_valid;
    int           lat;

    vecs[0] = '{a: 16'h5000, b: 16'h1234, z: 16'h3766, neg: 1'b0, lat: 4};
    vecs[1] = '{a: 16'h1234, b: 16'h5000, z: 16'h3766, neg: 1'b1, lat: 8};
    vecs[2] = '{a: 16'h0000, b: 16'h0001, z: 16'h0001, neg: 1'b1, lat: 8};
    vecs[3] = '{a: 16'h9999, b: 16'h9999, z: 16'h0000, neg: 1'b0, lat: 4};
    vecs[4] = '{a: 16'h1000, b: 16'h0001, z: 16'h0999, neg: 1'b0, lat: 4};
    vecs[5] = '{a: 16'h0000, b: 16'h9999, z: 16'h9999, neg: 1'b1, lat: 8};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    #12;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_z", bus.z_o, 0);
    check("rst_neg", bus.neg_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    foreach (vecs[i]) begin
      accept_op(vecs[i].a, vecs[i].b);
      check("tbl_busy", bus.in_ready, 1'b0);
      wait_done(lat);
      check($sformatf("tbl%0d_z", i), bus.z_o, vecs[i].z);
      check($sformatf("tbl%0d_neg", i), bus.neg_o, vecs[i].neg);
      check($sformatf("tbl%0d_err", i), bus.err_o, 1'b0);
      check($sformatf("tbl%0d_lat", i), lat, vecs[i].lat);
      take_result();
    end

    // Backpressure: hold result 5 clocks, in_valid pulses must be ignored.
    accept_op(16'h1234, 16'h5000);
    wait_done(lat);
    z_snap   = bus.z_o;
    neg_snap = bus.neg_o;
    check("hold_z_initial", z_snap, 16'h3766);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.a_i      = 16'h9999;
      bus.b_i      = 16'h0001;
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_z", bus.z_o, z_snap);
      check("hold_neg", bus.neg_o, neg_snap);
      check("hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    take_result();

    // Reset during SUB digit 2: outputs clear at once, no result appears.
    accept_op(16'h5000, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_z", bus.z_o, 0);
    check("mid_rst_neg", bus.neg_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("mid_rst_no_result", saw_valid, 1'b0);
    run_and_check("post_rst", 16'h5000, 16'h1234, 1'b1);

`ifdef BCD_CHECK_EN
    // Invalid digit sets err, blanks the result; next good op clears it.
    run_and_check("bad_digit", 16'h12A4, 16'h0000, 1'b0);
    accept_op(16'h12A4, 16'h0100);
    wait_done(lat);
    check("err_set", bus.err_o, 1'b1);
    check("err_z", bus.z_o, 0);
    check("err_neg", bus.neg_o, 1'b0);
    take_result();
    run_and_check("err_clear", 16'h0042, 16'h0050, 1'b1);
`endif

    // Random operands against the model.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = rand_operand();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_operand();
      run_and_check("rand", ra, rb, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
